// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine: mode encodings, FSM states
// and elaboration-time arctangent table generation.
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // Internal fixed-point scale used while summing the arctangent series.
    localparam int SERIES_FRAC = 60;

    function automatic int atan_frac(input int width);
        return width - 2;
    endfunction

    function automatic int idx_width(input int iter);
        return (iter > 1) ? $clog2(iter) : 1;
    endfunction

    // atan(1/n) scaled by 2^SERIES_FRAC via the alternating Taylor series.
    function automatic longint atan_inv(input longint n);
        longint p;
        longint acc;
        longint term;
        p   = (longint'(1) << SERIES_FRAC) / n;
        acc = 0;
        for (int unsigned k = 0; k < 64; k++) begin
            term = p / longint'(2 * k + 1);
            acc  = k[0] ? acc - term : acc + term;
            p    = p / n;
            p    = p / n;
        end
        return acc;
    endfunction

    // round(atan(2^-i) * 2^(width-2)); atan(1) is split as atan(1/2)+atan(1/3) for convergence.
    function automatic longint atan_entry(input int width, input int i);
        longint acc;
        int     shift;
        if (i == 0) acc = atan_inv(2) + atan_inv(3);
        else        acc = atan_inv(longint'(1) << i);
        shift = SERIES_FRAC - atan_frac(width);
        return (acc + (longint'(1) << (shift - 1))) >>> shift;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup; contents fixed at elaboration so the angle is
// available in the same cycle as its index.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 12,
    localparam int IDX_W = idx_width(ITER)
) (
    input  logic        [IDX_W-1:0] idx,
    output logic signed [WIDTH-1:0] angle
);

    logic [WIDTH-1:0] rom_data [2**IDX_W];

    // Unused slots above ITER-1 read as zero.
    for (genvar g = 0; g < 2**IDX_W; g++) begin : g_rom
        if (g < ITER) begin : g_val
            localparam longint VAL = atan_entry(WIDTH, g);
            assign rom_data[g] = WIDTH'(VAL);
        end else begin : g_pad
            assign rom_data[g] = '0;
        end
    end

    assign angle = rom_data[idx];

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative circular-mode CORDIC: one micro-rotation per clock, rotation or
// vectoring mode, start/busy/done handshake with registered held results.
module cordic_iter_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 12,
    parameter int GUARD = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    input  logic signed [WIDTH-1:0]   x_in,
    input  logic signed [WIDTH-1:0]   y_in,
    input  logic signed [WIDTH-1:0]   z_in,
    output logic                      busy,
    output logic                      done,
    output logic signed [WIDTH+GUARD-1:0] x_out,
    output logic signed [WIDTH+GUARD-1:0] y_out,
    output logic signed [WIDTH-1:0]   z_out
);

    localparam int XW    = WIDTH + GUARD;
    localparam int IDX_W = idx_width(ITER);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ITER - 1);

    state_t                   state;
    logic                     mode_q;
    logic        [IDX_W-1:0]  iter;
    logic signed [XW-1:0]     x_q, y_q;
    logic signed [WIDTH-1:0]  z_q;
    logic signed [XW-1:0]     x_sh, y_sh, x_nx, y_nx;
    logic signed [WIDTH-1:0]  z_nx, angle;
    logic                     pos;

    cordic_atan_rom #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_rom (
        .idx   (iter),
        .angle (angle)
    );

    always_comb begin
        x_sh = x_q >>> iter;
        y_sh = y_q >>> iter;
        // pos means d = +1
        pos  = (mode_q == MODE_VEC) ? y_q[XW-1] : ~z_q[WIDTH-1];
        if (pos) begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - angle;
        end else begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + angle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_ROT;
            iter   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_q    <= {{GUARD{x_in[WIDTH-1]}}, x_in};
                        y_q    <= {{GUARD{y_in[WIDTH-1]}}, y_in};
                        z_q    <= z_in;
                        mode_q <= mode;
                        iter   <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    x_q <= x_nx;
                    y_q <= y_nx;
                    z_q <= z_nx;
                    if (iter == LAST) begin
                        x_out <= x_nx;
                        y_out <= y_nx;
                        z_out <= z_nx;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        iter  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Bench for cordic_iter_engine: directed handshake/accuracy steps plus random vectors
// against a real-arithmetic reference, on ITER=12, ITER=1 and ITER=14 builds.
module tb_cordic_iter_engine;

    localparam int W  = 16;
    localparam int G  = 2;
    localparam int XW = W + G;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mode = 1'b0;
    logic start_m = 1'b0, start_1 = 1'b0, start_14 = 1'b0;
    logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;

    logic busy_m, done_m, busy_1, done_1, busy_14, done_14;
    logic signed [XW-1:0] x_m, y_m, x_1, y_1, x_14, y_14;
    logic signed [W-1:0]  z_m, z_1, z_14;

    int checks = 0;
    int errors = 0;
    int atan_tab [16];

    always #5 clk = ~clk;

    cordic_iter_engine #(.WIDTH(W), .ITER(12), .GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_m), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy_m), .done(done_m), .x_out(x_m), .y_out(y_m), .z_out(z_m)
    );

    cordic_iter_engine #(.WIDTH(W), .ITER(1), .GUARD(G)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy_1), .done(done_1), .x_out(x_1), .y_out(y_1), .z_out(z_1)
    );

    cordic_iter_engine #(.WIDTH(W), .ITER(W-2), .GUARD(G)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start_14), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy_14), .done(done_14), .x_out(x_14), .y_out(y_14), .z_out(z_14)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        checks++;
        assert ((d <= tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    function automatic logic get_done(input int w);
        case (w)
            0:       return done_m;
            1:       return done_1;
            default: return done_14;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return busy_m;
            1:       return busy_1;
            default: return busy_14;
        endcase
    endfunction

    function automatic longint get_x(input int w);
        case (w)
            0:       return longint'(x_m);
            1:       return longint'(x_1);
            default: return longint'(x_14);
        endcase
    endfunction

    function automatic longint get_y(input int w);
        case (w)
            0:       return longint'(y_m);
            1:       return longint'(y_1);
            default: return longint'(y_14);
        endcase
    endfunction

    function automatic longint get_z(input int w);
        case (w)
            0:       return longint'(z_m);
            1:       return longint'(z_1);
            default: return longint'(z_14);
        endcase
    endfunction

    function automatic int iter_of(input int w);
        case (w)
            0:       return 12;
            1:       return 1;
            default: return W - 2;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start_m  = v;
            1:       start_1  = v;
            default: start_14 = v;
        endcase
    endtask

    // Behavioural CORDIC from the micro-rotation equations, angle table from $atan.
    task automatic cordic_ref(input int iter, input bit md, input int x, input int y, input int z,
                              output longint rx, output longint ry, output longint rz);
        longint xv, yv, zv, xs, ys;
        bit pos;
        xv = x; yv = y; zv = z;
        for (int i = 0; i < iter; i++) begin
            pos = md ? (yv < 0) : (zv >= 0);
            xs = xv >>> i;
            ys = yv >>> i;
            if (pos) begin
                xv = xv - ys; yv = yv + xs; zv = zv - atan_tab[i];
            end else begin
                xv = xv + ys; yv = yv - xs; zv = zv + atan_tab[i];
            end
            zv = longint'(shortint'(zv));
        end
        rx = xv; ry = yv; rz = zv;
    endtask

    // Counts edges after the start edge until done; outputs must hold meanwhile.
    task automatic wait_done(input int w, input int already, output int lat);
        longint px, py, pz;
        px = get_x(w); py = get_y(w); pz = get_z(w);
        lat = already;
        do begin
            tick();
            lat++;
            if (!get_done(w)) begin
                chk("x_out hold during run", get_x(w), px);
                chk("z_out hold during run", get_z(w), pz);
                chk("y_out hold during run", get_y(w), py);
            end
        end while (!get_done(w) && lat < 60);
    endtask

    task automatic run_op(input int w, input bit md, input int x, input int y, input int z,
                          output int lat);
        x_in = W'(x); y_in = W'(y); z_in = W'(z); mode = md;
        set_start(w, 1'b1);
        tick();
        set_start(w, 1'b0);
        chk("busy after start", get_busy(w), 1);
        wait_done(w, 0, lat);
    endtask

    task automatic run_exact(input int w, input bit md, input int x, input int y, input int z,
                             input string tag);
        int lat;
        longint rx, ry, rz;
        run_op(w, md, x, y, z, lat);
        cordic_ref(iter_of(w), md, x, y, z, rx, ry, rz);
        chk({tag, " latency"}, lat, iter_of(w));
        chk({tag, " x_out"}, get_x(w), rx);
        chk({tag, " y_out"}, get_y(w), ry);
        chk({tag, " z_out"}, get_z(w), rz);
        chk({tag, " busy at done"}, get_busy(w), 0);
    endtask

    initial begin
        int lat;
        int seen;
        longint rx, ry, rz;
        bit md;
        int rxi, ryi, rzi;

        for (int i = 0; i < 16; i++)
            atan_tab[i] = $rtoi($floor($atan(2.0 ** (-i)) * 16384.0 + 0.5));

        repeat (2) tick();
        chk("reset busy", busy_m, 0);
        chk("reset done", done_m, 0);
        chk("reset x_out", longint'(x_m), 0);
        chk("reset y_out", longint'(y_m), 0);
        chk("reset z_out", longint'(z_m), 0);
        rst_n = 1'b1;
        tick();

        run_op(0, 1'b0, 9949, 0, 12868, lat);
        chk("rot +45 latency", lat, 12);
        chk("rot +45 done", done_m, 1);
        chk_near("rot +45 x_out", longint'(x_m), 11585, 8);
        chk_near("rot +45 y_out", longint'(y_m), 11585, 8);
        chk_near("rot +45 z_out", longint'(z_m), 0, 8);
        tick();
        chk("done single pulse", done_m, 0);
        chk_near("rot +45 x_out held", longint'(x_m), 11585, 8);

        run_op(0, 1'b0, 9949, 0, -12868, lat);
        chk("rot -45 latency", lat, 12);
        chk_near("rot -45 x_out", longint'(x_m), 11585, 8);
        chk_near("rot -45 y_out", longint'(y_m), -11585, 8);
        chk_near("rot -45 z_out", longint'(z_m), 0, 8);
        tick();

        run_op(0, 1'b1, 8192, 8192, 0, lat);
        chk("vec latency", lat, 12);
        chk_near("vec x_out", longint'(x_m), 19078, 10);
        chk_near("vec y_out", longint'(y_m), 0, 8);
        chk_near("vec z_out", longint'(z_m), 12868, 8);
        tick();

        // start pulsed mid-run must be ignored
        x_in = 16'sd5000; y_in = 16'sd3000; z_in = 16'sd7000; mode = 1'b0;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        repeat (3) tick();
        x_in = -16'sd1234; y_in = 16'sd777; z_in = -16'sd9000;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        wait_done(0, 4, lat);
        chk("ignored start latency", lat, 12);
        cordic_ref(12, 1'b0, 5000, 3000, 7000, rx, ry, rz);
        chk("ignored start x_out", longint'(x_m), rx);
        chk("ignored start y_out", longint'(y_m), ry);
        chk("ignored start z_out", longint'(z_m), rz);
        seen = 0;
        repeat (16) begin
            tick();
            if (done_m || busy_m) seen++;
        end
        chk("no queued second op", seen, 0);

        // back-to-back: second start issued in the done cycle
        run_exact(0, 1'b0, 12000, -4000, 20000, "b2b first");
        run_exact(0, 1'b1, 15000, -9000, 0, "b2b second");
        tick();

        // reset during a run
        x_in = 16'sd3000; y_in = 16'sd3000; z_in = 16'sd4000; mode = 1'b0;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid reset busy", busy_m, 0);
        chk("mid reset done", done_m, 0);
        chk("mid reset x_out", longint'(x_m), 0);
        chk("mid reset y_out", longint'(y_m), 0);
        chk("mid reset z_out", longint'(z_m), 0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (14) begin
            tick();
            if (done_m || busy_m) seen++;
        end
        chk("no done after abort", seen, 0);
        run_exact(0, 1'b0, 3000, 3000, 4000, "after reset");
        tick();

        for (int w = 0; w < 3; w++) begin
            for (int n = 0; n < 12; n++) begin
                md = $urandom_range(0, 1) == 1;
                if (md) begin
                    rxi = int'($urandom_range(0, 32767));
                    ryi = int'($urandom_range(0, 65535)) - 32768;
                    rzi = int'($urandom_range(0, 65535)) - 32768;
                end else begin
                    rxi = int'($urandom_range(0, 65535)) - 32768;
                    ryi = int'($urandom_range(0, 65535)) - 32768;
                    rzi = int'($urandom_range(0, 57016)) - 28508;
                end
                run_exact(w, md, rxi, ryi, rzi, "random");
                if ($urandom_range(0, 1) == 1) tick();
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
